sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  Expands one padded 512-bit SHA-256 message block into the round words W[0..ROUNDS-1].
//  Sits directly downstream of the header padder/block splitter. That stage emits the
//  padded blocks: two for the 80-byte header pass, one for the 256-bit digest re-hash.
//  Streams one 32-bit word per accepted beat to the compression-round stage.
//  Uses a 16-word sliding window; no 64-word storage.
// PARAMETERS
//  ROUNDS   64   words emitted per block; legal range 16..64
// PORTS
//  clk        in   1    system clock; all logic on rising edge
//  rst        in   1    synchronous reset, active-high
//  blk_valid  in   1    padder presents a block on blk_data
//  blk_ready  out  1    schedule can accept a block this cycle
//  blk_data   in   512  block, big-endian: W[0]=blk_data[511:480] ... W[15]=blk_data[31:0]
//  w_valid    out  1    w_data holds a valid round word
//  w_ready    in   1    compression stage consumes w_data this cycle
//  w_data     out  32   round word W[w_index]
//  w_index    out  6    round number t of w_data, 0..ROUNDS-1
//  w_last     out  1    high with w_valid when w_index == ROUNDS-1
//  busy       out  1    high while a block is being streamed
// BEHAVIOUR
//  - Reset (clk edge with rst=1): state=IDLE, w_valid=0, w_data=0, w_index=0, w_last=0,
//    busy=0, window cleared. blk_ready=0 while rst is high.
//  - blk_ready=1 in the first cycle after rst deasserts.
//  - FSM states: IDLE, STREAM.
//  - IDLE behaviour:
//    - blk_ready=1, w_valid=0, busy=0.
//    - On blk_valid & blk_ready: load R[0..15] = W[0..15] from blk_data, t=0, go to STREAM.
//  - STREAM behaviour:
//    - blk_ready=0, busy=1, w_valid=1, w_data=R[0], w_index=t, w_last=(t==ROUNDS-1).
//  - Latency: block accepted on edge N -> w_valid=1 with W[0] in cycle N+1.
//  - Handshake: a word transfers on a cycle with w_valid & w_ready.
//    - While w_valid & !w_ready, w_data, w_index and w_last hold stable. The window does not shift.
//    - blk_valid is ignored whenever blk_ready=0. The upstream block is held, not dropped.
//  - On each transfer with t < ROUNDS-1:
//    - R[i] <= R[i+1] for i=0..14.
//    - R[15] <= s1(R[14]) + R[9] + s0(R[1]) + R[0], taken mod 2^32 (carry discarded).
//    - t <= t+1.
//  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
//  - For t <= 15 the words emitted are the loaded words, unmodified. Expansion supplies W[16] onward.
//  - Transfer with t == ROUNDS-1 (w_last): next state IDLE, w_valid=0, t=0.
//    - blk_ready rises the following cycle, so there is a one-cycle bubble between blocks.
//  - A ready-but-unconsumed last word stays presented indefinitely.
//  - Reset mid-STREAM: current block is discarded. No further words are emitted.
//    Outputs return to their reset values on that same edge.
//  - ROUNDS=16: no expansion occurs; W[15] carries w_last.
// TESTING
//  1. Reset: hold rst 3 cycles with blk_valid=1 -> blk_ready=0, w_valid=0, w_data=0.
//     Then blk_ready=1 in the first cycle after release.
//  2. "abc" block (61626380, 13 x 00000000, 00000000, 00000018), w_ready=1.
//     -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000.
//     -> All 64 words match a C reference model. w_last only on w_index=63.
//  3. All-zero block -> 64 words of 00000000.
//     -> Exactly 64 transfers, then blk_ready=1 one cycle after the w_last transfer.
//  4. Backpressure: random w_ready (~50%) with the "abc" block.
//     -> Same 64-word sequence as test 2.
//     -> w_data and w_index stable on every stalled cycle; no skipped or repeated index.
//  5. Back-to-back: blk_valid held high with header block 1, then block 2.
//     -> Block 2 is not accepted until IDLE; its W0 appears 2 cycles after block 1's w_last transfer.
//  6. Reset mid-stream: assert rst at w_index=20 -> w_valid=0 next cycle.
//     -> A new block then streams from W0 correctly.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into ROUNDS round words.
// Ports: blk_* block handshake in, w_* word stream out, busy while streaming.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_index,
  output logic         w_last,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [31:0] w_next;
  logic        accept;
  logic        xfer;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Ready drops combinationally with rst so nothing is taken during reset.
  assign blk_ready = (state == IDLE) && !rst;
  assign accept    = blk_valid && blk_ready;
  assign xfer      = w_valid && w_ready;
  assign w_data    = win[0];

  // win[0] holds W[t]; this forms W[t+16].
  assign w_next = s1(win[14]) + win[9] + s0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      w_valid <= 1'b0;
      w_index <= 6'd0;
      w_last  <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) begin
              win[i] <= blk_data[511-32*i -: 32];
            end
            state   <= STREAM;
            w_valid <= 1'b1;
            busy    <= 1'b1;
            w_index <= 6'd0;
            w_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (w_last) begin
              state   <= IDLE;
              w_valid <= 1'b0;
              busy    <= 1'b0;
              w_index <= 6'd0;
              w_last  <= 1'b0;
            end else begin
              for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
              end
              win[15] <= w_next;
              w_index <= w_index + 6'd1;
              w_last  <= (w_index + 6'd1) == LAST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: directed blocks, backpressure, back-to-back, reset.
// Words are checked against a full 64-word reference expansion and a vector table.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_index;
  logic         w_last;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_index   (w_index),
    .w_last    (w_last),
    .busy      (busy)
  );

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic [511:0] blocks [4];
  logic [31:0]  mw [64];
  logic [31:0]  cap [4][64];
  vec_t         vt [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) mw[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      mw[i] = (rotr(mw[i-2], 17) ^ rotr(mw[i-2], 19) ^ (mw[i-2] >> 10))
            + mw[i-7]
            + (rotr(mw[i-15], 7) ^ rotr(mw[i-15], 18) ^ (mw[i-15] >> 3))
            + mw[i-16];
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Present a block until accepted; afterwards keep or drop blk_valid.
  task automatic send_block(input logic [511:0] b, input logic keep,
                            input logic [511:0] nxt);
    int cyc = 0;
    logic ok = 1'b0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      blk_valid = 1'b1;
      blk_data  = b;
      #1;
      cyc++;
      ok = blk_ready;
    end
    chk("blk_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (keep) blk_data = nxt;
    else blk_valid = 1'b0;
  endtask

  // Consume 64 words with w_ready asserted pct% of cycles.
  task automatic collect(input int sel, input int pct);
    int n = 0;
    int cyc = 0;
    int stall_err = 0;
    int idx_err = 0;
    int last_err = 0;
    int word_err = 0;
    int rdy_err = 0;
    int busy_err = 0;
    logic pstall = 1'b0;
    logic [31:0] pd = '0;
    logic [5:0] pi = '0;
    model(blocks[sel]);
    while (n < 64 && cyc < 3000) begin
      @(negedge clk);
      w_ready = ($urandom_range(0, 99) < pct);
      #1;
      cyc++;
      if (blk_ready) rdy_err++;
      if (w_valid && !busy) busy_err++;
      if (pstall && (!w_valid || w_data !== pd || w_index !== pi))
        stall_err++;
      pstall = w_valid && !w_ready;
      pd = w_data;
      pi = w_index;
      if (w_valid && w_ready) begin
        if (w_index !== 6'(n)) idx_err++;
        if (w_last !== (n == 63)) last_err++;
        if (w_data !== mw[n]) begin
          if (word_err == 0)
            $display("FAIL word[%0d]: got %08h expected %08h", n, w_data, mw[n]);
          word_err++;
        end
        cap[sel][n] = w_data;
        n++;
      end
    end
    chk("word_count", 32'(n), 32'd64);
    chk("word_errors", 32'(word_err), 32'd0);
    chk("index_errors", 32'(idx_err), 32'd0);
    chk("last_errors", 32'(last_err), 32'd0);
    chk("stall_errors", 32'(stall_err), 32'd0);
    chk("ready_in_stream", 32'(rdy_err), 32'd0);
    chk("busy_errors", 32'(busy_err), 32'd0);
  endtask

  initial begin
    logic found;
    blocks[0] = {32'h61626380, {14{32'h0}}, 32'h00000018};
    blocks[1] = '0;
    for (int i = 0; i < 16; i++)
      blocks[2][511-32*i -: 32] = 32'h9e3779b9 * (i + 1);
    blocks[3] = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h80000000,
                 {11{32'h0}}, 32'h00000280};

    vt[0] = '{"abc_w0",  0, 0,  32'h61626380};
    vt[1] = '{"abc_w1",  0, 1,  32'h00000000};
    vt[2] = '{"abc_w15", 0, 15, 32'h00000018};
    vt[3] = '{"abc_w16", 0, 16, 32'h61626380};
    vt[4] = '{"abc_w17", 0, 17, 32'h000f0000};
    vt[5] = '{"zero_w0", 1, 0,  32'h00000000};
    vt[6] = '{"zero_w40", 1, 40, 32'h00000000};
    vt[7] = '{"zero_w63", 1, 63, 32'h00000000};

    // Reset held three cycles with a block offered.
    rst = 1'b1;
    blk_valid = 1'b1;
    blk_data = blocks[0];
    w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_blk_ready", 32'(blk_ready), 32'd0);
      chk("rst_w_valid", 32'(w_valid), 32'd0);
      chk("rst_w_data", w_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    blk_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(blk_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // "abc" block, full throughput, then first-word latency.
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data = blocks[0];
    @(negedge clk);
    blk_valid = 1'b0;
    #1;
    chk("latency_valid", 32'(w_valid), 32'd1);
    chk("latency_index", 32'(w_index), 32'd0);
    collect(0, 100);

    // All-zero block, bubble before next acceptance.
    send_block(blocks[1], 1'b0, '0);
    collect(1, 100);
    @(negedge clk);
    #1;
    chk("bubble_ready", 32'(blk_ready), 32'd1);
    chk("bubble_valid", 32'(w_valid), 32'd0);

    for (int i = 0; i < 8; i++)
      chk(vt[i].name, cap[vt[i].sel][vt[i].idx], vt[i].exp);

    // Backpressure with the "abc" block.
    send_block(blocks[0], 1'b0, '0);
    collect(0, 50);

    // Back-to-back: block 2 held valid throughout block 1.
    send_block(blocks[2], 1'b1, blocks[3]);
    collect(2, 100);
    @(negedge clk);
    w_ready = 1'b0;
    #1;
    chk("b2b_gap_valid", 32'(w_valid), 32'd0);
    chk("b2b_gap_ready", 32'(blk_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_w0_valid", 32'(w_valid), 32'd1);
    chk("b2b_w0_index", 32'(w_index), 32'd0);
    chk("b2b_w0_data", w_data, blocks[3][511:480]);
    blk_valid = 1'b0;
    collect(3, 100);

    // Reset in the middle of a stream.
    send_block(blocks[0], 1'b0, '0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      w_ready = 1'b1;
      #1;
      if (w_valid && w_index == 6'd20) begin
        rst = 1'b1;
        found = 1'b1;
      end
    end
    chk("reach_idx20", 32'(found), 32'd1);
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(w_valid), 32'd0);
    chk("mid_rst_data", w_data, 32'd0);
    chk("mid_rst_index", 32'(w_index), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    send_block(blocks[2], 1'b0, '0);
    collect(2, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
